logic_unit_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit; successor to the fixed 32-bit NAND array.

---
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 tb/tb_logic_unit_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered 8-op bitwise logic unit feeding an in-order DEPTH-entry result FIFO.
// Ports: clk, rst_n; in_valid/in_ready/OP/A/B in; out_valid/out_ready/C/level out;
// Z/P head flags only when LOGIC_PIPE_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 OP,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           C,
`ifdef LOGIC_PIPE_FLAGS_EN
  output logic                       Z,
  output logic                       P,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
`ifdef LOGIC_PIPE_FLAGS_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH;
`endif

  logic [WIDTH-1:0] res;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    head;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    lvl;
  logic             push;
  logic             pop;

  always_comb begin
    res = '0;
    unique case (OP)
      3'b000: res = A & B;
      3'b001: res = A | B;
      3'b010: res = A ^ B;
      3'b011: res = ~(A & B);
      3'b100: res = ~(A | B);
      3'b101: res = ~(A ^ B);
      3'b110: res = ~A;
      3'b111: res = A;
    endcase
  end

  // Flags are computed on entry so the head flags come straight from storage.
`ifdef LOGIC_PIPE_FLAGS_EN
  assign wdata = {~|res, ^res, res};
`else
  assign wdata = res;
`endif

  // in_ready depends only on the occupancy register: a pop cannot
  // free a slot for a push in the same cycle.
  assign in_ready  = (lvl != LW'(DEPTH));
  assign out_valid = (lvl != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = lvl;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  assign C = out_valid ? head[WIDTH-1:0] : '0;
`ifdef LOGIC_PIPE_FLAGS_EN
  assign Z = out_valid ? head[WIDTH+1] : 1'b1;
  assign P = out_valid ? head[WIDTH]   : 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed spec cases plus random traffic.
// Expected results and occupancy come from a bench-side model of the spec rules.
module tb_logic_unit_pipe;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  c;
  logic [LW-1:0] level;
`ifdef LOGIC_PIPE_FLAGS_EN
  logic          z;
  logic          p;
`endif

  logic_unit_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OP        (op),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (c),
`ifdef LOGIC_PIPE_FLAGS_EN
    .Z         (z),
    .P         (p),
`endif
    .level     (level)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb [$];
  int           exp_level = 0;
  bit           rnd_run = 0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Occupancy model: accept while not full, pop while not empty.
  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) begin
      exp_level = 0;
    end else begin
      n = exp_level;
      if (in_valid && exp_level != D) n++;
      if (out_ready && exp_level != 0) n--;
      exp_level = n;
    end
  end

  // Monitor: checks handshake state and head result every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", 64'(level), 64'(exp_level));
      chk("in_ready", 64'(in_ready), 64'(exp_level != D));
      chk("out_valid", 64'(out_valid), 64'(exp_level != 0));
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got C=%0h want none", c);
        end else begin
          chk("C", 64'(c), 64'(sb[0]));
`ifdef LOGIC_PIPE_FLAGS_EN
          chk("Z", 64'(z), 64'(sb[0] == '0));
          chk("P", 64'(p), 64'(^sb[0]));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("C_idle", 64'(c), 64'd0);
`ifdef LOGIC_PIPE_FLAGS_EN
        chk("Z_idle", 64'(z), 64'd1);
        chk("P_idle", 64'(p), 64'd0);
`endif
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] e);
    bit ok;
    ok = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (exp_level != D) ok = 1;
    end
    if (ok) begin
      sb.push_back(e);
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no acceptance want acceptance");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic rsend(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    send(o, x, y, ref_op(o, x, y));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && exp_level == 0) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got level=%0d want 0", exp_level);
    end
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_level"}, 64'(level), 64'd0);
    chk({nm, "_C"}, 64'(c), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
`ifdef LOGIC_PIPE_FLAGS_EN
    chk({nm, "_Z"}, 64'(z), 64'd1);
    chk({nm, "_P"}, 64'(p), 64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, released mid-cycle
    #3 reset_check("rst0");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed ops, each arriving the cycle after acceptance
    out_ready = 1'b1;
    send(3'b011, 32'hF0F0_1234, 32'hFF00_00FF, 32'h0FFF_FFCB);
    send(3'b010, 32'hF0F0_1234, 32'hFF00_00FF, 32'h0FF0_12CB);
    send(3'b110, 32'hF0F0_1234, 32'hFF00_00FF, 32'h0F0F_EDCB);
    drain();

    // backpressure: two accepted, third held until a slot frees
    out_ready = 1'b0;
    rsend(3'd0, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    rsend(3'd1, 32'h1234_5678, 32'h8000_0001);
    fork
      rsend(3'd5, 32'hAAAA_5555, 32'h5555_AAAA);
    join_none
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait fork;
    drain();

    // steady push+pop at level 1
    rsend(3'd2, 32'h1111_1111, 32'h2222_2222);
    for (int i = 0; i < 8; i++) begin
      rsend(3'(i), $urandom, $urandom);
    end
    drain();

    // reset while full
    out_ready = 1'b0;
    rsend(3'd4, 32'h0, 32'h0);
    rsend(3'd7, 32'h0000_00A5, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_check("rst_full");
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'b000, '1, '1, '1);
    drain();

    // flag cases
    send(3'b000, 32'h0, 32'hFFFF_FFFF, 32'h0);
    send(3'b111, 32'h0000_0007, 32'h1234_0000, 32'h0000_0007);
    drain();

    // random traffic with random consumer stalls
    rnd_run = 1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          rsend(3'($urandom_range(0, 7)), $urandom, $urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_run = 0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
